// File: rtl/lsu.sv
// lsu: RV32 load/store unit driving a req/ack data-memory port
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start_i         access request from execute (sampled only in IDLE)
//   is_store_i      1 = store, 0 = load
//   funct3_i        access size / signedness (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   addr_i          effective address from the ALU
//   wdata_i         store data (rs2)
//   busy_o          high while the access is in flight (core stall)
//   done_o          one-cycle completion pulse
//   fault_o         valid with done_o: misaligned, illegal funct3 or ack timeout
//   rdata_o         extended load result, held between completions
//   mem_*_o         registered memory request: req, we, word address, byte enables, lane data
//   mem_ack_i       memory acknowledge
//   mem_rdata_i     memory read data (valid with mem_ack_i)
module lsu #(
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        is_store_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        fault_o,
   output logic [31:0] rdata_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i
);
   typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_e;
   state_e      state_q, state_d;
   logic        mem_req_q, mem_we_q, fault_q;
   logic [31:0] mem_addr_q, mem_wdata_q, rdata_q;
   logic [3:0]  mem_be_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic [15:0] cnt_q;
   logic        illegal, misaligned, bad, accept, timeout_hit, enter_resp, fault_d;
   logic [3:0]  be_d;
   logic [31:0] wd_d, ext, rd_d;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   assign illegal    = is_store_i ? (funct3_i[2] | (&funct3_i[1:0]))
                                  : ((&funct3_i[1:0]) | (funct3_i[2] & funct3_i[1]));
   assign misaligned = funct3_i[0] ? addr_i[0] : funct3_i[1] ? |addr_i[1:0] : 1'b0;
   assign bad        = illegal | misaligned;
   assign accept     = (state_q == S_IDLE) & start_i & ~bad;
   // counter holds the number of ack-less BUS cycles already elapsed; this cycle makes one more
   assign timeout_hit = (ACK_TIMEOUT != 0) && (({1'b0, cnt_q} + 17'd1) == 17'(ACK_TIMEOUT));
   assign be_d = funct3_i[1] ? 4'b1111 : funct3_i[0] ? (addr_i[1] ? 4'b1100 : 4'b0011)
                                       : 4'b0001 << addr_i[1:0];
   assign wd_d = funct3_i[1] ? wdata_i : funct3_i[0] ? {2{wdata_i[15:0]}} : {4{wdata_i[7:0]}};
   assign lane_b = 8'(mem_rdata_i >> {off_q, 3'b000});
   assign lane_h = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
   // f3_q[2] selects zero extension (LBU/LHU)
   assign ext = f3_q[1] ? mem_rdata_i
              : f3_q[0] ? {{16{~f3_q[2] & lane_h[15]}}, lane_h}
              : {{24{~f3_q[2] & lane_b[7]}}, lane_b};
   assign enter_resp = (state_d == S_RESP) & (state_q != S_RESP);
   // entering RESP straight from IDLE is always the fault path; from BUS only a timeout faults
   assign fault_d = (state_q == S_IDLE) | ~mem_ack_i;
   assign rd_d    = ((state_q == S_BUS) & mem_ack_i & ~mem_we_q) ? ext : 32'd0;
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end
   always_comb begin
      state_d = (state_q == S_IDLE) ? (start_i ? (bad ? S_RESP : S_BUS) : S_IDLE)
              : (state_q == S_BUS)  ? ((mem_ack_i | timeout_hit) ? S_RESP : S_BUS)
              : S_IDLE;
   end
   always_comb begin
      busy_o  = state_q != S_IDLE;
      done_o  = state_q == S_RESP;
      fault_o = (state_q == S_RESP) & fault_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         f3_q        <= '0;
         off_q       <= '0;
         cnt_q       <= '0;
         fault_q     <= 1'b0;
         rdata_q     <= '0;
      end else begin
         mem_req_q <= state_d == S_BUS;
         if (accept) begin
            mem_we_q    <= is_store_i;
            mem_addr_q  <= {addr_i[31:2], 2'b00};
            mem_be_q    <= be_d;
            mem_wdata_q <= wd_d;
            f3_q        <= funct3_i;
            off_q       <= addr_i[1:0];
            cnt_q       <= '0;
         end else if ((state_q == S_BUS) & ~mem_ack_i) begin
            cnt_q <= cnt_q + 16'd1;
         end
         if (enter_resp) begin
            fault_q <= fault_d;
            rdata_q <= rd_d;
         end
      end
   end
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_be_o    = mem_be_q;
   assign mem_wdata_o = mem_wdata_q;
   assign rdata_o     = rdata_q;
endmodule

// File: doc/lsu.md
# lsu

Load/store unit that sits directly downstream of the execute-stage ALU in the RV32 core. It takes the ALU result as the effective address and the rs2 value as store data, and runs a req/ack transaction on the data-memory port. For stores it produces word-aligned address, byte enables and lane-replicated write data. For loads it produces the sign- or zero-extended result. It stalls the core via `busy` until the access completes, faults or times out.

## Interface
- `ACK_TIMEOUT`, 255: number of cycles in BUS without `mem_ack` before aborting with fault; 0 disables the timeout; legal range 0–65535.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: access request from execute stage; sampled only in IDLE.
- `is_store` in 1: 1 = store, 0 = load.
- `funct3` in 3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- `addr` in 32: effective address (ALU result).
- `wdata` in 32: store data (rs2).
- `busy` out 1: high whenever state ≠ IDLE; core stalls on it.
- `done` out 1: one-cycle completion pulse.
- `fault` out 1: valid with `done`; misaligned address, illegal funct3 or timeout.
- `rdata` out 32: extended load result; held between completions.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 32, `mem_be` out 4, `mem_wdata` out 32: memory request (all registered).
- `mem_ack` in 1, `mem_rdata` in 32: memory response.

## Operation
- The FSM has three states: IDLE, BUS and RESP.
- **IDLE**
  - On `start` with a legal, aligned access: latch the fields, drive the `mem_*` outputs and go to BUS.
  - On `start` with an illegal or misaligned access: go straight to RESP with fault; `mem_req` is never raised.
- **Illegal and misaligned accesses**
  - Illegal funct3: loads 011/110/111; stores with any funct3 > 010.
  - Misaligned: half access with `addr[0]`=1; word access with `addr[1:0]`≠00.
- **BUS**
  - `mem_req`=1, with all `mem_*` outputs held stable until `mem_ack`.
  - `mem_ack` seen: capture the load data and go to RESP.
  - Timeout counter reaches `ACK_TIMEOUT` (and it is nonzero): go to RESP with `fault`=1.
- **RESP**
  - `done`=1 for exactly one cycle, `fault` as latched; next state IDLE.
  - `start` is ignored in RESP.
- **Address and write data**
  - `mem_addr` = {addr[31:2], 2'b00}.
  - `mem_we` = `is_store`.
  - Word: `mem_be` = 1111, `mem_wdata` = `wdata`.
  - Half: `mem_be` = addr[1] ? 1100 : 0011, `mem_wdata` = {2{wdata[15:0]}}.
  - Byte: `mem_be` = 0001 << addr[1:0], `mem_wdata` = {4{wdata[7:0]}}.
  - Loads drive the same `mem_be` values.
- **Load extraction**
  - Byte lane = `mem_rdata[8*addr[1:0] +: 8]`; half lane = `mem_rdata[16*addr[1] +: 16]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through unchanged.
- **`rdata` update rule**
  - Updated only on entry to RESP: load success → extended value; store or fault → 0.
  - Otherwise it holds its value.
- `mem_ack` outside BUS is ignored.
- The timeout counter is 16 bits, cleared on entry to BUS and incremented on each BUS cycle without ack.

## Timing
- **Reset:** state IDLE. `busy`, `done`, `fault`, `mem_req`, `mem_we` = 0; `mem_addr`, `mem_be`, `mem_wdata`, `rdata` = 0; counter 0.
- **Reset mid-transaction:** the FSM returns to IDLE and `mem_req` drops on the edge where `rst` is sampled high. No `done` is issued, and a late ack is ignored.
- **Normal access:** `start` sampled at edge 0.
  - BUS from edge 0; `mem_req` high in cycle 1.
  - If ack arrives in cycle 1, RESP is entered at edge 1: `done` high in cycle 2, IDLE in cycle 3.
  - Minimum start-to-done latency is 2 cycles. Each extra ack wait cycle adds 1.
- **Fault path:** RESP is entered at edge 0, so `done`/`fault` are high in cycle 1.
- **Timeout:** `mem_req` stays high for exactly `ACK_TIMEOUT` cycles, then RESP with fault. An ack arriving in the same cycle the counter hits the limit wins: success, no fault.
- **Back-to-back:** a new `start` is accepted in the first IDLE cycle after RESP.

## Test plan
- **LB / LBU lane extraction:** LB at addr 0x0000_1003, `mem_rdata` 0x8012_3456, ack in first BUS cycle.
  - Expect `mem_addr` 0x1000 and `mem_be` 1000.
  - `done` occurs 2 cycles after start, with `rdata` 0xFFFF_FF80.
  - Repeating as LBU gives 0x0000_0080.
- **SH upper half:** SH at addr 0x2002, `wdata` 0xDEAD_BEEF.
  - Expect `mem_we`=1, `mem_be` 1100, `mem_wdata` 0xBEEF_BEEF, `mem_addr` 0x2000.
  - `rdata` = 0 at `done`.
- **Misaligned LW:** LW at 0x3001.
  - Expect `done`=`fault`=1 one cycle after start, `mem_req` never high, `rdata` 0.
  - The same result is required for load funct3 = 011.
- **Delayed ack:** ack arrives 5 cycles after `mem_req` rises.
  - Expect `mem_req`/`mem_addr`/`mem_be` stable for all 5 cycles.
  - `done` occurs exactly 1 cycle after ack; `busy` stays high throughout.
- **Timeout:** `ACK_TIMEOUT`=4, no ack.
  - Expect `mem_req` high exactly 4 cycles, then `done`+`fault`.
  - With ack asserted in that 4th cycle instead: `done` with `fault`=0.
- **Reset during BUS:** `rst` asserted in cycle 2 of BUS.
  - Expect `mem_req`=0 after that edge and no `done`.
  - An ack arriving afterwards must not change `rdata`.
